// File: rtl/rail_gate_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rail_gate_pkg
//  Description : Shared light codes and train presence detector state
//                encoding, plus a timer-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package rail_gate_pkg;

   // Track light codes, shared with the gate controller
   typedef enum logic [1:0] {
      RED    = 2'd0,
      YELLOW = 2'd1,
      GREEN  = 2'd2
   } light_e;

   // Presence detector state encoding
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      OCCUPIED = 2'd2,
      CLEARING = 2'd3
   } det_state_e;

   // Bits needed for a timer that counts from 0 up to and including limit
   function automatic int tmr_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/train_presence_detector_if.sv
`default_nettype none
// ============================================================================
//  Module      : train_presence_detector_if
//  Description : Trackside sensors, returned track light and the occupancy
//                request/status bundle of the train presence detector.
//                master = trackside / gate controller side, slave = detector.
//  Revision    : 1.0  initial release
// ============================================================================
interface train_presence_detector_if
   import rail_gate_pkg::*;
#(
   parameter int CNT_W = 8
);
   logic             entry_sensor;
   logic             exit_sensor;
   light_e           track;
   logic             train;
   logic [CNT_W-1:0] axle_count;
   logic             fault;
   logic             grant_timeout;

   modport master (
      output entry_sensor, exit_sensor, track,
      input  train, axle_count, fault, grant_timeout
   );

   modport slave (
      input  entry_sensor, exit_sensor, track,
      output train, axle_count, fault, grant_timeout
   );
endinterface
`default_nettype wire

// File: rtl/train_presence_detector_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : sensor_debounce
//  Description : 2-FF synchronizer, level debouncer requiring DEB_CYCLES
//                consecutive differing samples, and a one-cycle pulse on each
//                accepted 0->1 level change.
//  Revision    : 1.0  initial release
// ============================================================================
module sensor_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  wire logic clk,
   input  wire logic clr,
   input  wire logic i_raw,
   output logic      o_pulse
);
   localparam int                 c_DEB_W    = $clog2(DEB_CYCLES + 1);
   localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);

   logic               r_meta;
   logic               r_sync;
   logic               r_level;
   logic [c_DEB_W-1:0] r_cnt;
   logic               r_pulse;

   // Bring the raw trackside level into the clk domain
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_raw;
         r_sync <= r_meta;
      end
   end

   // Accept a new level only after DEB_CYCLES consecutive differing samples;
   // the accepting edge also emits the rising-edge pulse
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_level <= 1'b0;
         r_cnt   <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_pulse <= 1'b0;
         if (r_sync == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == c_DEB_LAST) begin
            r_level <= r_sync;
            r_cnt   <= '0;
            r_pulse <= r_sync;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/train_presence_detector.sv
`default_nettype none
// ============================================================================
//  Module      : train_presence_detector
//  Description : Counts axles into/out of the crossing section, raises the
//                registered `train` request while occupied, holds it for
//                CLEAR_HOLD cycles after the section empties, and flags
//                counter faults and a missing GREEN grant.
//                Optional macro AXLE_FAULT_LOCK_EN: once fault is set,
//                `train` is forced high until clr.
//  Revision    : 1.0  initial release
// ============================================================================
module train_presence_detector
   import rail_gate_pkg::*;
#(
   parameter int CNT_W         = 8,
   parameter int DEB_CYCLES    = 4,
   parameter int CLEAR_HOLD    = 8,
   parameter int GRANT_TIMEOUT = 16
) (
   input  wire logic                  clk,
   input  wire logic                  clr,
   train_presence_detector_if.slave   bus
);
   localparam logic [CNT_W-1:0]   c_CNT_MAX    = '1;
   localparam int                 c_GTO_W      = tmr_width(GRANT_TIMEOUT);
   localparam int                 c_HOLD_W     = tmr_width(CLEAR_HOLD);
   localparam logic [c_GTO_W-1:0] c_GTO_LIMIT  = c_GTO_W'(GRANT_TIMEOUT);
   localparam logic [c_HOLD_W-1:0] c_HOLD_LIMIT = c_HOLD_W'(CLEAR_HOLD);

   logic                w_entry_pulse;
   logic                w_exit_pulse;

   logic [CNT_W-1:0]    r_count;
   logic [CNT_W-1:0]    w_count_nxt;
   logic                r_fault;
   logic                w_fault_nxt;

   det_state_e          r_state;
   det_state_e          w_state_nxt;
   logic [c_GTO_W-1:0]  r_gto_tmr;
   logic [c_GTO_W-1:0]  w_gto_tmr_nxt;
   logic [c_GTO_W-1:0]  w_gto_inc;
   logic [c_HOLD_W-1:0] r_hold_tmr;
   logic [c_HOLD_W-1:0] w_hold_tmr_nxt;
   logic [c_HOLD_W-1:0] w_hold_inc;
   logic                r_gto_flag;
   logic                w_gto_flag_nxt;
   logic                r_train;
   logic                w_train_nxt;

   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_entry_deb (
      .clk     (clk),
      .clr     (clr),
      .i_raw   (bus.entry_sensor),
      .o_pulse (w_entry_pulse)
   );

   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_exit_deb (
      .clk     (clk),
      .clr     (clr),
      .i_raw   (bus.exit_sensor),
      .o_pulse (w_exit_pulse)
   );

   // Net axle count: saturate at both ends and flag the attempt
   always_comb begin
      w_count_nxt = r_count;
      w_fault_nxt = r_fault;
      if (w_entry_pulse && !w_exit_pulse) begin
         if (r_count == c_CNT_MAX) w_fault_nxt = 1'b1;
         else                      w_count_nxt = r_count + 1'b1;
      end else if (w_exit_pulse && !w_entry_pulse) begin
         if (r_count == '0) w_fault_nxt = 1'b1;
         else               w_count_nxt = r_count - 1'b1;
      end
   end

   // Axle count and sticky fault registers
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_count <= '0;
         r_fault <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_fault <= w_fault_nxt;
      end
   end

   // The FSM looks at the count being loaded this edge, so train moves on
   // the same edge as axle_count
   assign w_gto_inc  = (r_gto_tmr  == c_GTO_LIMIT)  ? r_gto_tmr  : r_gto_tmr  + 1'b1;
   assign w_hold_inc = (r_hold_tmr == c_HOLD_LIMIT) ? r_hold_tmr : r_hold_tmr + 1'b1;

   // Next state, timers, grant-timeout flag and the train request
   always_comb begin
      w_state_nxt    = r_state;
      w_gto_tmr_nxt  = r_gto_tmr;
      w_hold_tmr_nxt = r_hold_tmr;
      w_gto_flag_nxt = r_gto_flag;
      case (r_state)
         IDLE: begin
            if (w_count_nxt != '0) begin
               w_state_nxt   = REQ;
               w_gto_tmr_nxt = '0;
            end
         end
         REQ: begin
            w_gto_tmr_nxt = w_gto_inc;
            if (w_gto_inc == c_GTO_LIMIT) w_gto_flag_nxt = 1'b1;
            if (w_count_nxt == '0) begin
               w_state_nxt    = CLEARING;
               w_hold_tmr_nxt = '0;
            end else if (bus.track == GREEN) begin
               w_state_nxt = OCCUPIED;
            end
         end
         OCCUPIED: begin
            if (w_count_nxt == '0) begin
               w_state_nxt    = CLEARING;
               w_hold_tmr_nxt = '0;
            end
         end
         CLEARING: begin
            if (w_count_nxt != '0) begin
               if (bus.track == GREEN) begin
                  w_state_nxt = OCCUPIED;
               end else begin
                  w_state_nxt   = REQ;
                  w_gto_tmr_nxt = '0;
               end
            end else begin
               w_hold_tmr_nxt = w_hold_inc;
               if (w_hold_inc == c_HOLD_LIMIT) w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
`ifdef AXLE_FAULT_LOCK_EN
      // Fail-safe: a counting fault keeps the gate closed until clr
      w_train_nxt = (w_state_nxt != IDLE) || w_fault_nxt;
`else
      w_train_nxt = (w_state_nxt != IDLE);
`endif
   end

   // State, timers and registered outputs
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state    <= IDLE;
         r_gto_tmr  <= '0;
         r_hold_tmr <= '0;
         r_gto_flag <= 1'b0;
         r_train    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_gto_tmr  <= w_gto_tmr_nxt;
         r_hold_tmr <= w_hold_tmr_nxt;
         r_gto_flag <= w_gto_flag_nxt;
         r_train    <= w_train_nxt;
      end
   end

   assign bus.train         = r_train;
   assign bus.axle_count    = r_count;
   assign bus.fault         = r_fault;
   assign bus.grant_timeout = r_gto_flag;

endmodule
`default_nettype wire
